// File: rtl/ssd1331_spi_tx_if.sv
// Command-side handshake between the OLED init/command FSMs and the SSD1331 SPI transmitter.
interface ssd1331_spi_tx_if;
    logic [7:0] spi_data;
    logic       spi_start;
    logic       dc_in;
    logic       spi_done;
    logic       busy;

    modport master (
        output spi_data,
        output spi_start,
        output dc_in,
        input  spi_done,
        input  busy
    );

    modport slave (
        input  spi_data,
        input  spi_start,
        input  dc_in,
        output spi_done,
        output busy
    );
endinterface

// File: rtl/ssd1331_spi_tx.sv
// Write-only SPI mode-3 byte transmitter for the SSD1331 OLED: one MSB-first byte per CS# frame.
module ssd1331_spi_tx #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ssd1331_spi_tx_if.slave   bus,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              dc_out
);

    localparam int DW     = $clog2(CLK_DIV) + 1;
    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW     = $clog2(CS_MAX) + 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [CW-1:0]   cs_cnt_q, cs_cnt_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;
    logic            dc_q, dc_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        cs_cnt_d  = cs_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        dc_d      = dc_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.spi_start) begin
                    // MSB goes straight to the pin; the remaining seven bits wait in shift_q.
                    shift_d   = bus.spi_data[6:0];
                    mosi_d    = bus.spi_data[7];
                    dc_d      = bus.dc_in;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    cs_cnt_d  = {CW{1'b0}};
                    bit_cnt_d = 3'd0;
                    state_d   = SETUP;
                end else begin
                    state_d   = IDLE;
                end
            end
            SETUP: begin
                if (cs_cnt_q == SETUP_LAST) begin
                    cs_cnt_d  = {CW{1'b0}};
                    div_cnt_d = {DW{1'b0}};
                    sclk_d    = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    cs_cnt_d  = cs_cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = {DW{1'b0}};
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == 3'd7) begin
                        // Last bit stays on MOSI through the CS# hold time.
                        bit_cnt_d = 3'd0;
                        cs_cnt_d  = {CW{1'b0}};
                        state_d   = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        mosi_d    = shift_q[6];
                        shift_d   = {shift_q[5:0], 1'b0};
                        sclk_d    = 1'b0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            HOLD: begin
                if (cs_cnt_q == HOLD_LAST) begin
                    cs_cnt_d = {CW{1'b0}};
                    cs_n_d   = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    mosi_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cs_cnt_d = cs_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b1;
                mosi_d  = 1'b0;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
            div_cnt_q <= {DW{1'b0}};
            cs_cnt_q  <= {CW{1'b0}};
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            cs_cnt_q  <= cs_cnt_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            dc_q      <= dc_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign cs_n         = cs_n_q;
    assign dc_out       = dc_q;
    assign bus.spi_done = done_q;
    assign bus.busy     = busy_q;

endmodule
